ack_bus_requester: RTL and testbench
====================================

# ack_bus_requester

Per-source initiator agent for the shared open-drain ACK bus. Each source module (MEM, SHA, AES, CTRL) instantiates one. It counts completion events from its core and raises `req` toward the ACK bus arbiter until each event is granted. It checks that every grant carries its own source ID, and it drops `req` for one cycle after every grant so that a lower-priority source (higher ID) can win the wired-AND arbitration.

## Interface
Parameters:
- `SOURCE_ID`, 2'b01: this agent's fixed ACK bus ID (00 MEM, 01 SHA, 10 AES, 11 CTRL).
- `PEND_W`, 3: pending-counter width. Maximum outstanding events = 2^PEND_W − 1.
- `TIMEOUT`, 64: cycles spent in REQ without a grant before `timeout_err` sets. 0 disables the check.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `done_pulse`  in  1  one-cycle completion event from the core.
- `ack_ready`  in  1  one-hot grant line from the arbiter for this source.
- `ack_event`  in  1  arbiter broadcast: an arbitration was won this cycle.
- `winner_source_id`  in  2  arbiter broadcast winner ID.
- `clr_err`  in  1  synchronous clear of all sticky error flags.
- `req`  out  1  registered request to the ACK bus and arbiter.
- `grant_pulse`  out  1  registered one-cycle pulse per consumed grant.
- `pending_cnt`  out  PEND_W  outstanding un-granted events.
- `busy`  out  1  `pending_cnt != 0` or state is not IDLE.
- `overflow`  out  1  sticky: event lost at full count.
- `timeout_err`  out  1  sticky: REQ held TIMEOUT cycles without a grant.
- `proto_err`  out  1  sticky: inconsistent or unexpected grant.

## Operation
- **Valid grant:** `grant = (state==REQ) & ack_ready & ack_event & (winner_source_id==SOURCE_ID)`, sampled at the rising edge.
- **Protocol error:** `ack_ready` high while state != REQ, or `ack_ready` high while `ack_event` is low or the ID mismatches, sets `proto_err`. The grant is not counted.
- **State machine:** IDLE, REQ, HOLD. `req = (state==REQ)`.
  - IDLE → REQ when `done_pulse | (pending_cnt != 0)`.
  - REQ → HOLD on a valid grant. Otherwise stay in REQ.
  - HOLD → REQ if the post-update count is nonzero, else → IDLE. HOLD always lasts exactly 1 cycle.
- **Pending counter:** next = cnt + done_pulse − grant.
  - A simultaneous increment and decrement leave the count unchanged.
  - `done_pulse` at the maximum count with no grant: the count saturates and `overflow` sets.
  - A decrement at 0 cannot occur, because grant requires state REQ, which implies cnt ≥ 1.
- **`grant_pulse`:** high for the one cycle after each valid grant.
- **Timeout counter:**
  - Clears on entry to REQ and on every grant.
  - Increments each REQ cycle without a grant, saturating at TIMEOUT.
  - Sets `timeout_err` when it reaches TIMEOUT.
  - `req` stays asserted; the agent never abandons a request.
- **Sticky flags:** `clr_err` clears all three. If a set condition occurs in the same cycle as `clr_err`, set wins.

## Timing
- **Reset:** `rst_n` low asynchronously forces the state to IDLE and `req`=0, `grant_pulse`=0, `pending_cnt`=0, `busy`=0, all error flags 0, and the timeout counter 0. Reset mid-REQ drops `req` immediately and discards all pending events.
- **Request latency:** `done_pulse` sampled at edge N with state IDLE gives `req`=1 from edge N onward, i.e. 1 cycle of latency.
- **Grant handshake:** a grant sampled at edge M gives `req`=0 and `grant_pulse`=1 for cycle M..M+1.
  - If the count is still nonzero, `req` reasserts at edge M+1.
  - Minimum spacing between grants to the same agent is 2 cycles.
- **Arbiter timing:** the arbiter is combinational, so `ack_ready` answers the `req` of the same cycle.
- **Back-to-back events:** `done_pulse` on consecutive cycles accumulate in `pending_cnt`; none are lost below saturation.
- **`busy`:** combinational from registered state and count.

## Test plan
- **Single event:** reset; `done_pulse` at cycle 2; arbiter grants immediately → `req` 1 for exactly one cycle, `grant_pulse` at cycle 4, `pending_cnt` 1→0, state returns to IDLE, no flags.
- **Burst:** 3 consecutive `done_pulse`, grant every cycle `req` is high → `req` pattern 1,0,1,0,1,0, three `grant_pulse`s, count 3→0.
- **Overflow:** PEND_W=3 with no grant → 8 pulses give `pending_cnt`=7 and `overflow`=1. `clr_err` then gives `overflow`=0 with the count still 7.
- **Simultaneous events:** `done_pulse` in the same cycle as a grant with count 2 → count stays 2, state goes to HOLD, then to REQ.
- **Timeout:** TIMEOUT=4, `req` high with no grant → `timeout_err` set after 4 cycles in REQ, `req` still 1. A later grant is consumed normally.
- **Protocol errors and reset:**
  - `ack_ready`=1 with `winner_source_id`≠SOURCE_ID → `proto_err`=1, count unchanged.
  - `ack_ready` in IDLE → `proto_err`=1.
  - `rst_n` low mid-REQ → all outputs 0 asynchronously.

Source files
------------

// File: rtl/ack_bus_requester.sv
// Per-source ACK bus initiator: queues core completion events, requests the bus
// until each one is granted, and flags overflow, grant timeouts and bad grants.
module ack_bus_requester #(
  parameter logic [1:0]  SOURCE_ID = 2'b01,
  parameter int unsigned PEND_W    = 3,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done_pulse,
  input  logic              ack_ready,
  input  logic              ack_event,
  input  logic [1:0]        winner_source_id,
  input  logic              clr_err,
  output logic              req,
  output logic              grant_pulse,
  output logic [PEND_W-1:0] pending_cnt,
  output logic              busy,
  output logic              overflow,
  output logic              timeout_err,
  output logic              proto_err
);

  localparam int unsigned       TO_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [TO_W-1:0]   TO_LIM  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'((TIMEOUT == 0) ? 32'd0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t            state;
  logic [TO_W-1:0]   to_cnt;
  logic              grant;
  logic              bad_ack;
  logic              cnt_sat;
  logic              to_hit;
  logic [PEND_W-1:0] cnt_next;

  always_comb begin
    grant    = (state == REQ) & ack_ready & ack_event & (winner_source_id == SOURCE_ID);
    bad_ack  = ack_ready & ~grant;
    cnt_sat  = done_pulse & ~grant & (pending_cnt == CNT_MAX);
    to_hit   = (TIMEOUT != 0) && (state == REQ) && !grant && (to_cnt == TO_LAST);
    cnt_next = pending_cnt;
    if (done_pulse && !grant && !cnt_sat)
      cnt_next = pending_cnt + 1'b1;
    else if (grant && !done_pulse)
      cnt_next = pending_cnt - 1'b1;
  end

  assign busy = (pending_cnt != '0) || (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req         <= 1'b0;
      grant_pulse <= 1'b0;
      pending_cnt <= '0;
      to_cnt      <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      pending_cnt <= cnt_next;
      grant_pulse <= grant;
      // A set condition coincident with clr_err keeps the flag set.
      overflow    <= cnt_sat | (overflow & ~clr_err);
      timeout_err <= to_hit  | (timeout_err & ~clr_err);
      proto_err   <= bad_ack | (proto_err & ~clr_err);
      case (state)
        IDLE: begin
          if (done_pulse || (pending_cnt != '0)) begin
            state  <= REQ;
            req    <= 1'b1;
            to_cnt <= '0;
          end
        end
        REQ: begin
          if (grant) begin
            state  <= HOLD;
            req    <= 1'b0;
            to_cnt <= '0;
          end else if (to_cnt != TO_LIM) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        HOLD: begin
          // One dead cycle lets a higher-ID source win the wired-AND bus.
          if (cnt_next != '0) begin
            state  <= REQ;
            req    <= 1'b1;
            to_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ack_bus_requester.sv
// Bench for ack_bus_requester: directed scenarios with literal expectations plus
// a randomized run compared every cycle against an event-level reference model.
module tb_ack_bus_requester;

  localparam logic [1:0] SID  = 2'b01;
  localparam int         PW   = 3;
  localparam int         TO   = 4;
  localparam int         MAXC = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          done_pulse;
  logic          ack_ready;
  logic          ack_event;
  logic [1:0]    winner_source_id;
  logic          clr_err;
  logic          req;
  logic          grant_pulse;
  logic [PW-1:0] pending_cnt;
  logic          busy;
  logic          overflow;
  logic          timeout_err;
  logic          proto_err;

  ack_bus_requester #(
    .SOURCE_ID (SID),
    .PEND_W    (PW),
    .TIMEOUT   (TO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .done_pulse       (done_pulse),
    .ack_ready        (ack_ready),
    .ack_event        (ack_event),
    .winner_source_id (winner_source_id),
    .clr_err          (clr_err),
    .req              (req),
    .grant_pulse      (grant_pulse),
    .pending_cnt      (pending_cnt),
    .busy             (busy),
    .overflow         (overflow),
    .timeout_err      (timeout_err),
    .proto_err        (proto_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the agent requests whenever events are outstanding,
  // except in the cycle right after a grant.
  int m_cnt, m_wait;
  bit m_req, m_gp, m_ovf, m_to, m_pe;
  bit g, ovf_set, to_set, nreq;
  int nc, nw;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_wait <= 0; m_req <= 0; m_gp <= 0;
      m_ovf <= 0; m_to <= 0; m_pe <= 0;
    end else begin
      g       = m_req && ack_ready && ack_event && (winner_source_id == SID);
      nc      = m_cnt + int'(done_pulse) - int'(g);
      ovf_set = 1'b0;
      if (nc > MAXC) begin
        nc      = MAXC;
        ovf_set = 1'b1;
      end
      nreq   = (nc != 0) && !g;
      nw     = m_wait;
      to_set = 1'b0;
      if (g || (!m_req && nreq))
        nw = 0;
      else if (m_req && nw < TO) begin
        nw++;
        if (nw == TO) to_set = 1'b1;
      end
      m_cnt  <= nc;
      m_req  <= nreq;
      m_gp   <= g;
      m_wait <= nw;
      m_ovf  <= ovf_set || (m_ovf && !clr_err);
      m_to   <= to_set  || (m_to && !clr_err);
      m_pe   <= (ack_ready && !g) || (m_pe && !clr_err);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req", req, m_req);
      chk("grant_pulse", grant_pulse, m_gp);
      chk("pending_cnt", pending_cnt, m_cnt);
      chk("busy", busy, (m_cnt != 0) || m_req || m_gp);
      chk("overflow", overflow, m_ovf);
      chk("timeout_err", timeout_err, m_to);
      chk("proto_err", proto_err, m_pe);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    done_pulse = 1'b0; ack_ready = 1'b0; ack_event = 1'b0;
    winner_source_id = SID; clr_err = 1'b0;
  endtask

  task automatic grant_if_req();
    ack_ready = req; ack_event = req; winner_source_id = SID;
  endtask

  task automatic drain();
    int k = 0;
    idle_in();
    while (busy === 1'b1 && k < 40) begin
      grant_if_req();
      cyc();
      k++;
    end
    idle_in();
    chk("drain_idle", busy, 0);
  endtask

  task automatic clear_flags();
    idle_in();
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
  endtask

  int exp_req[6] = '{1, 0, 1, 0, 1, 0};
  int ngp;

  initial begin
    rst_n = 1'b0;
    idle_in();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", req, 0);
    chk("rst_cnt", pending_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {overflow, timeout_err, proto_err, grant_pulse}, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    cyc();

    // single event, granted immediately
    done_pulse = 1'b1;
    cyc();
    chk("single_req", req, 1);
    chk("single_cnt", pending_cnt, 1);
    done_pulse = 1'b0;
    grant_if_req();
    cyc();
    chk("single_req_drop", req, 0);
    chk("single_gp", grant_pulse, 1);
    chk("single_cnt0", pending_cnt, 0);
    idle_in();
    cyc();
    chk("single_idle", {busy, req, grant_pulse, proto_err}, 0);

    // burst of three with grant on every request
    ngp = 0;
    for (int i = 0; i < 6; i++) begin
      done_pulse = (i < 3);
      grant_if_req();
      cyc();
      chk("burst_req", req, exp_req[i]);
      ngp += int'(grant_pulse);
    end
    idle_in();
    cyc();
    chk("burst_grants", ngp, 3);
    chk("burst_busy", busy, 0);

    // overflow with no grants; timeout also fires while waiting
    for (int i = 0; i < 8; i++) begin
      done_pulse = 1'b1;
      cyc();
    end
    chk("ovf_cnt", pending_cnt, 7);
    chk("ovf_flag", overflow, 1);
    chk("ovf_req", req, 1);
    chk("ovf_timeout", timeout_err, 1);
    clear_flags();
    chk("ovf_clr", overflow, 0);
    chk("ovf_cnt_kept", pending_cnt, 7);
    chk("to_clr", timeout_err, 0);
    drain();

    // simultaneous event and grant at count 2
    done_pulse = 1'b1;
    cyc();
    cyc();
    chk("sim_cnt2", pending_cnt, 2);
    done_pulse = 1'b1;
    grant_if_req();
    cyc();
    chk("sim_cnt_kept", pending_cnt, 2);
    chk("sim_hold_req", req, 0);
    chk("sim_gp", grant_pulse, 1);
    idle_in();
    cyc();
    chk("sim_rereq", req, 1);
    drain();

    // timeout after four waiting cycles, then a normal grant
    done_pulse = 1'b1;
    cyc();
    done_pulse = 1'b0;
    repeat (3) cyc();
    chk("to_early", timeout_err, 0);
    cyc();
    chk("to_set", timeout_err, 1);
    chk("to_req_held", req, 1);
    grant_if_req();
    cyc();
    chk("to_grant_gp", grant_pulse, 1);
    chk("to_grant_cnt", pending_cnt, 0);
    clear_flags();
    chk("to_cleared", timeout_err, 0);

    // grant carrying another source's ID
    done_pulse = 1'b1;
    cyc();
    done_pulse = 1'b0;
    ack_ready = 1'b1; ack_event = 1'b1; winner_source_id = 2'b10;
    cyc();
    chk("pe_id", proto_err, 1);
    chk("pe_id_cnt", pending_cnt, 1);
    chk("pe_id_gp", grant_pulse, 0);
    clear_flags();
    chk("pe_clr", proto_err, 0);
    drain();

    // grant while idle, with and without a coincident clear
    ack_ready = 1'b1; ack_event = 1'b1;
    cyc();
    chk("pe_idle", proto_err, 1);
    chk("pe_idle_cnt", pending_cnt, 0);
    clr_err = 1'b1;
    cyc();
    chk("pe_set_wins", proto_err, 1);
    clear_flags();

    // asynchronous reset while requesting
    done_pulse = 1'b1;
    cyc();
    cyc();
    done_pulse = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", req, 0);
    chk("arst_cnt", pending_cnt, 0);
    chk("arst_busy", busy, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 599) != 0);
      done_pulse = ($urandom_range(0, 99) < 35);
      if (req) ack_ready = ($urandom_range(0, 99) < 60);
      else     ack_ready = ($urandom_range(0, 99) < 2);
      ack_event        = ack_ready ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 3) == 0);
      winner_source_id = ($urandom_range(0, 9) == 0) ? 2'($urandom) : SID;
      clr_err          = ($urandom_range(0, 99) < 4);
      cyc();
    end
    rst_n = 1'b1;
    idle_in();
    cyc();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
